// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is split into STAGES chunks,
// with carry/borrow and signed-overflow flags and a valid/ready stream handshake.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic [WIDTH-1:0]  r_a     [STAGES];
    logic [WIDTH-1:0]  r_b     [STAGES];
    logic [WIDTH-1:0]  r_s     [STAGES];
    logic [STAGES-1:0] r_cy;
    logic [STAGES-1:0] r_v;
    logic              r_ovf;

    logic [WIDTH-1:0]  w_a_in  [STAGES];
    logic [WIDTH-1:0]  w_b_in  [STAGES];
    logic [WIDTH-1:0]  w_s_in  [STAGES];
    logic [WIDTH-1:0]  w_s_nxt [STAGES];
    logic [CW:0]       w_chunk [STAGES];
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_cy_nxt;
    logic [STAGES-1:0] w_v_in;
    logic              w_ovf_nxt;
    logic              w_adv;

    // Global stall: the whole pipe moves only when the output slot is free or drained.
    assign w_adv     = !r_v[LAST] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[LAST];
    assign s         = r_s[LAST];
    assign c         = r_cy[LAST];
    assign ovf       = r_ovf;

    // Stage inputs and per-stage chunk add; stage 0 is fed straight from the ports.
    always_comb begin
        w_a_in[0] = x;
        w_b_in[0] = sub ? ~y : y;
        w_s_in[0] = '0;
        w_cin[0]  = sub;
        w_v_in[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
            w_cin[k]  = r_cy[k-1];
            w_v_in[k] = r_v[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_chunk[k] = (CW+1)'(w_a_in[k][k*CW +: CW])
                       + (CW+1)'(w_b_in[k][k*CW +: CW])
                       + (CW+1)'(w_cin[k]);
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*CW +: CW] = w_chunk[k][CW-1:0];
            w_cy_nxt[k] = w_chunk[k][CW];
        end
        // Carry into the MSB is a ^ b ^ sum at that bit; XOR with carry-out gives overflow.
        w_ovf_nxt = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1]
                  ^ w_s_nxt[LAST][WIDTH-1] ^ w_cy_nxt[LAST];
    end

    // Pipeline registers: all stages advance together or hold together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_cy  <= '0;
            r_ovf <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            r_v   <= w_v_in;
            r_cy  <= w_cy_nxt;
            r_ovf <= w_ovf_nxt;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_s[k] <= w_s_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, random stalled stream, mid-stream reset,
// and an exhaustive 4-bit single-stage instance.
module tb_pipelined_addsub;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, c, ovf;
    logic [15:0] x, y, s;
    logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, c4, ovf4;
    logic [3:0]  x4, y4, s4;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_rcv = 0;
    logic [17:0] q[$];
    vec_t        vt[5];

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c(c), .ovf(ovf)
    );

    pipelined_addsub #(.WIDTH(4), .STAGES(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .x(x4), .y(y4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .s(s4), .c(c4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference from the arithmetic definition: returns {ovf, c, s} with s in the low 16 bits.
    function automatic logic [17:0] model(input int w, input int xv, input int yv, input bit sb);
        int m, half, sx, sy, r, se;
        bit ce, oe;
        m    = 1 << w;
        half = m / 2;
        sx   = (xv >= half) ? xv - m : xv;
        sy   = (yv >= half) ? yv - m : yv;
        r    = sb ? sx - sy : sx + sy;
        oe   = (r >= half) || (r < -half);
        ce   = sb ? (xv >= yv) : (xv + yv >= m);
        se   = sb ? (xv - yv + m) % m : (xv + yv) % m;
        return {oe, ce, 16'(se)};
    endfunction

    // Stream scoreboard: every valid output must equal the oldest outstanding accepted beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("stream_result", 32'({ovf, c, s}), 32'(q[0]));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_rcv++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(16, int'(x), int'(y), sub));
                n_acc++;
            end
        end
    end

    task automatic send_one(input vec_t v);
        int lat;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x = v.x; y = v.y; sub = v.sub;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat >= 20) break;
            @(posedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("vector_result", 32'({ovf, c, s}), 32'({v.ovf, v.c, v.s}));
        @(posedge clk);
        @(negedge clk);
        check("valid_one_cycle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   base, rbase, cyc;
        logic stale;
        vt[0] = '{x: 16'hFFFF, y: 16'h0001, sub: 1'b0, s: 16'h0000, c: 1'b1, ovf: 1'b0};
        vt[1] = '{x: 16'h0005, y: 16'h0007, sub: 1'b1, s: 16'hFFFE, c: 1'b0, ovf: 1'b0};
        vt[2] = '{x: 16'h8000, y: 16'h0001, sub: 1'b1, s: 16'h7FFF, c: 1'b1, ovf: 1'b1};
        vt[3] = '{x: 16'h7FFF, y: 16'h0001, sub: 1'b0, s: 16'h8000, c: 1'b0, ovf: 1'b1};
        vt[4] = '{x: 16'h1234, y: 16'h4321, sub: 1'b0, s: 16'h5555, c: 1'b0, ovf: 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; x4 = '0; y4 = '0; sub4 = 1'b0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_scv", 32'({ovf, c, s}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) send_one(vt[i]);

        // Random mixed stream with random valid and 50% backpressure.
        base  = n_acc;
        rbase = n_rcv;
        cyc   = 0;
        while (n_acc < base + 64 && cyc < 3000) begin
            @(posedge clk);
            #2;
            in_valid  = 1'($urandom_range(0, 1));
            x         = 16'($urandom);
            y         = 16'($urandom);
            sub       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("random_accepted_64", 32'(n_acc - base >= 64), 32'd1);
        check("random_drain_empty", 32'(q.size()), 32'd0);
        check("random_count_equal", 32'(n_rcv - rbase), 32'(n_acc - base));

        // Fill the pipe with four beats, then reset while they are in flight.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            in_valid  = 1'b1;
            out_ready = 1'b0;
            x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #2;
        check("full_before_reset", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_scv", 32'({ovf, c, s}), 32'd0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_after_reset", 32'(stale), 32'd0);
        send_one(vt[2]);

        // Exhaustive single-stage 4-bit instance, back-to-back at one-cycle latency.
        for (int i = 0; i <= 512; i++) begin
            @(posedge clk);
            #2;
            if (i < 512) begin
                in_valid4 = 1'b1;
                x4   = 4'(i);
                y4   = 4'(i >> 4);
                sub4 = 1'(i >> 8);
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                logic [17:0] e;
                e = model(4, (i - 1) % 16, ((i - 1) / 16) % 16, 1'((i - 1) / 256));
                check("w4_result", 32'({out_valid4, ovf4, c4, 12'h000, s4}),
                      32'({1'b1, e}));
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("w4_idle", 32'({out_valid4, in_ready4}), 32'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
